// File: rtl/sync_fifo_pf_pkg.sv
// sync_fifo_pf_pkg: sizing helpers and reset values shared by the single-clock FIFO.
package sync_fifo_pf_pkg;

    function automatic int depth_f(input int asize);
        return 1 << asize;
    endfunction

    // One extra bit so a full FIFO (DEPTH words) is distinguishable from empty.
    function automatic int cnt_w_f(input int asize);
        return asize + 1;
    endfunction

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic almost_full;
        logic almost_empty;
        logic ovf;
        logic udf;
    } flags_t;

    localparam flags_t FLAGS_RST = '{
        wfull: 1'b0, rempty: 1'b1, almost_full: 1'b0,
        almost_empty: 1'b1, ovf: 1'b0, udf: 1'b0
    };

    localparam logic RDATA_RST = 1'b0;

endpackage

// File: rtl/sync_fifo_pf_mem.sv
// sync_fifo_pf_mem: DEPTH x DSIZE register array, one write port, asynchronous read port.
module sync_fifo_pf_mem
    import sync_fifo_pf_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem_q [depth_f(ASIZE)];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_pf.sv
// sync_fifo_pf: single-clock FIFO with registered flags, thresholds, fill count and sticky errors.
// Define SYNC_FIFO_PF_FWFT_EN for first-word-fall-through read data.
module sync_fifo_pf
    import sync_fifo_pf_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int ASIZE  = 4,
    parameter int AFULL  = 2**ASIZE - 2,
    parameter int AEMPTY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             err_clr,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             ovf,
    output logic             udf
);

    localparam int DEPTH = depth_f(ASIZE);
    localparam int CW    = cnt_w_f(ASIZE);

    if (AFULL < 1 || AFULL > DEPTH || AEMPTY < 0 || AEMPTY >= DEPTH) begin : g_bad_cfg
        $fatal(1, "sync_fifo_pf: AFULL must be 1..DEPTH and AEMPTY 0..DEPTH-1");
    end

    logic [CW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    flags_t           flags_q, flags_d;
    logic             we, re;
    logic [DSIZE-1:0] mem_rdata;

    // Flags derive from next count so they always agree with count.
    always_comb begin
        we                   = winc & ~flags_q.wfull;
        re                   = rinc & ~flags_q.rempty;
        wptr_d               = wptr_q + CW'(we);
        rptr_d               = rptr_q + CW'(re);
        count_d              = count_q + CW'(we) - CW'(re);
        flags_d.wfull        = count_d == CW'(DEPTH);
        flags_d.rempty       = count_d == '0;
        flags_d.almost_full  = count_d >= CW'(AFULL);
        flags_d.almost_empty = count_d <= CW'(AEMPTY);
        flags_d.ovf          = (winc & flags_q.wfull) | (flags_q.ovf & ~err_clr);
        flags_d.udf          = (rinc & flags_q.rempty) | (flags_q.udf & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

    sync_fifo_pf_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[ASIZE-1:0]),
        .rdata (mem_rdata)
    );

`ifdef SYNC_FIFO_PF_FWFT_EN
    assign rdata = mem_rdata;
`else
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= {DSIZE{RDATA_RST}};
        else if (re) rdata_q <= mem_rdata;
    end

    assign rdata = rdata_q;
`endif

    assign count        = count_q;
    assign wfull        = flags_q.wfull;
    assign rempty       = flags_q.rempty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign ovf          = flags_q.ovf;
    assign udf          = flags_q.udf;

endmodule

// File: tb/tb_sync_fifo_pf.sv
// tb_sync_fifo_pf: randomized and directed stimulus against a queue-based reference model.
module tb_sync_fifo_pf;

    localparam int DSIZE = 8, ASIZE = 3, AFULL = 6, AEMPTY = 1, DEPTH = 8;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;
    logic [DSIZE-1:0] rdata;
    logic             wfull, rempty, almost_full, almost_empty, ovf, udf;
    logic [ASIZE:0]   count;

    int nchk = 0, nerr = 0;

    sync_fifo_pf #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL(AFULL), .AEMPTY(AEMPTY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wdata        (wdata),
        .winc         (winc),
        .rinc         (rinc),
        .err_clr      (err_clr),
        .rdata        (rdata),
        .wfull        (wfull),
        .rempty       (rempty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus sticky error bits.
    logic [DSIZE-1:0] mq[$];
    logic [DSIZE-1:0] m_rdata;
    logic             m_ovf, m_udf;

    always @(posedge clk or negedge rst_n) begin : model
        int n;
        if (!rst_n) begin
            mq.delete();
            m_rdata <= '0;
            m_ovf   <= 1'b0;
            m_udf   <= 1'b0;
        end else begin
            n = mq.size();
            m_ovf <= (winc && n == DEPTH) || (m_ovf && !err_clr);
            m_udf <= (rinc && n == 0) || (m_udf && !err_clr);
            if (rinc && n != 0) begin
                m_rdata <= mq[0];
                void'(mq.pop_front());
            end
            if (winc && n != DEPTH) mq.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        chk("count", 32'(count), mq.size());
        chk("rempty", 32'(rempty), 32'(mq.size() == 0));
        chk("wfull", 32'(wfull), 32'(mq.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AEMPTY));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
`ifdef SYNC_FIFO_PF_FWFT_EN
        if (mq.size() != 0) chk("rdata_head", 32'(rdata), 32'(mq[0]));
`else
        chk("rdata", 32'(rdata), 32'(m_rdata));
`endif
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
        winc = w; rinc = r; wdata = d; err_clr = c;
        @(posedge clk);
        #2;
        winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    endtask

    task automatic read_word(input logic [7:0] exp);
`ifdef SYNC_FIFO_PF_FWFT_EN
        chk("fwft_read", 32'(rdata), 32'(exp));
        cyc(0, 1, 8'h00, 0);
`else
        cyc(0, 1, 8'h00, 0);
        chk("std_read", 32'(rdata), 32'(exp));
`endif
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_rempty", 32'(rempty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_wfull", 32'(wfull), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf_udf", 32'({ovf, udf}), 0);
`ifndef SYNC_FIFO_PF_FWFT_EN
        chk("rst_rdata", 32'(rdata), 0);
`endif
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 8'(i), 0);
            chk("fill_count", 32'(count), i);
            if (i == 1) chk("aempty_after1", 32'(almost_empty), 1);
            if (i == 2) chk("aempty_after2", 32'(almost_empty), 0);
            if (i == 5) chk("afull_after5", 32'(almost_full), 0);
            if (i == 6) chk("afull_after6", 32'(almost_full), 1);
            if (i == 7) chk("wfull_after7", 32'(wfull), 0);
            if (i == 8) chk("wfull_after8", 32'(wfull), 1);
        end
        cyc(1, 0, 8'hAA, 0);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_count", 32'(count), 8);
        for (int i = 1; i <= 8; i++) read_word(8'(i));
        chk("drained_rempty", 32'(rempty), 1);
        cyc(0, 0, 8'h00, 1);
        chk("ovf_clr", 32'(ovf), 0);
        cyc(0, 1, 8'h00, 0);
        chk("udf_set", 32'(udf), 1);
`ifndef SYNC_FIFO_PF_FWFT_EN
        chk("udf_rdata_hold", 32'(rdata), 8'h08);
`endif
        cyc(1, 1, 8'h55, 0);
        chk("wr_rd_empty_count", 32'(count), 1);
        read_word(8'h55);
        cyc(0, 0, 8'h00, 1);
        chk("udf_clr", 32'(udf), 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h10 + i), 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 8'(8'h20 + i), 0);
            chk("stream_count", 32'(count), 4);
        end
        cyc(1, 0, 8'h77, 0);
        chk("pre_rst_count", 32'(count), 5);
        winc = 1'b1; wdata = 8'h78;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_flags", 32'({wfull, rempty, almost_full, almost_empty, ovf, udf}), 6'b010100);
`ifndef SYNC_FIFO_PF_FWFT_EN
        chk("mid_rst_rdata", 32'(rdata), 0);
`endif
        winc = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        cyc(1, 0, 8'h3C, 0);
`ifdef SYNC_FIFO_PF_FWFT_EN
        chk("fwft_rempty", 32'(rempty), 0);
        chk("fwft_3c", 32'(rdata), 8'h3C);
`endif
        read_word(8'h3C);
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                8'($urandom), 1'($urandom_range(0, 99) < 5));
        for (int i = 0; i < 10; i++) cyc(0, 1, 8'h00, 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
